// File: rtl/apb_pkg.sv
// Shared types and width helpers for the queued APB4 master.
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

    localparam int BYTE_W = 8;

    function automatic int strb_width(input int data_w);
        return data_w / BYTE_W;
    endfunction

endpackage

// File: rtl/apb_cmd_fifo.sv
// Synchronous command FIFO; DEPTH must be a power of two so the pointers wrap naturally.
module apb_cmd_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             PCLK,
    input  logic             PRESETn,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (PTR_W + 1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // NOTE: the storage array is deliberately left unreset; only pointers and count
    // are reset, and an entry is never read before it has been written.
    always_ff @(posedge PCLK) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (PTR_W + 1)'(1);
                2'b01:   count <= count - (PTR_W + 1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/apb_master_q.sv
// Queued APB4 master: buffers commands, runs one SETUP/ACCESS transfer at a time,
// and returns each result (read data, error, timeout) through a one-entry response register.
module apb_master_q
    import apb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 16,
    localparam int STRB_W = strb_width(DATA_W)
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    input  logic [STRB_W-1:0] cmd_strb,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_timeout,
    output logic              busy,
    output logic [ADDR_W-1:0] PADDR,
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [DATA_W-1:0] PWDATA,
    output logic [STRB_W-1:0] PSTRB,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic              PREADY,
    input  logic              PSLVERR
);

    localparam int ENTRY_W = 1 + ADDR_W + DATA_W + STRB_W;
    localparam int CNT_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

    apb_state_e        state;
    apb_state_e        next_state;
    logic              fifo_full;
    logic              fifo_empty;
    logic              push;
    logic              pop;
    logic [ENTRY_W-1:0] head;
    logic              h_write;
    logic [ADDR_W-1:0] h_addr;
    logic [DATA_W-1:0] h_wdata;
    logic [STRB_W-1:0] h_strb;
    logic [CNT_W-1:0]  wait_cnt;
    logic              slot_free;
    logic              done;
    logic              timeout_hit;

    assign push      = cmd_valid && cmd_ready;
    assign cmd_ready = !fifo_full;

    apb_cmd_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .push    (push),
        .pop     (pop),
        .wdata   ({cmd_write, cmd_addr, cmd_wdata, cmd_strb}),
        .head    (head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign {h_write, h_addr, h_wdata, h_strb} = head;

    // A new transfer may start only if its response will have somewhere to go.
    assign slot_free   = !rsp_valid || rsp_ready;
    assign done        = (state == ACCESS) && PREADY;
    assign timeout_hit = (TIMEOUT > 0) && (state == ACCESS) && !PREADY && (wait_cnt == CNT_LAST);

    // NOTE: every signal driven here gets its default first, so no path can infer a latch.
    always_comb begin
        next_state = state;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty && slot_free) begin
                    next_state = SETUP;
                    pop        = 1'b1;
                end
            end
            SETUP:   next_state = ACCESS;
            ACCESS: begin
                if (done || timeout_hit) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            PADDR  <= '0;
            PWRITE <= 1'b0;
            PWDATA <= '0;
            PSTRB  <= '0;
        end else if (pop) begin
            PADDR  <= h_addr;
            PWRITE <= h_write;
            PWDATA <= h_wdata;
            PSTRB  <= h_write ? h_strb : '0;
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            wait_cnt <= '0;
        end else if (state == SETUP) begin
            wait_cnt <= '0;
        end else if ((TIMEOUT > 0) && (state == ACCESS) && !PREADY && !timeout_hit) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
        end
    end

    // A completion or abort always wins over a same-cycle handshake: the slot was
    // guaranteed free when the transfer started, so nothing is overwritten.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
        end else if (done) begin
            rsp_valid   <= 1'b1;
            rsp_rdata   <= PWRITE ? '0 : PRDATA;
            rsp_err     <= PSLVERR;
            rsp_timeout <= 1'b0;
        end else if (timeout_hit) begin
            rsp_valid   <= 1'b1;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b1;
            rsp_timeout <= 1'b1;
        end else if (rsp_valid && rsp_ready) begin
            rsp_valid   <= 1'b0;
        end
    end

    assign PSEL    = (state != IDLE);
    assign PENABLE = (state == ACCESS);
    assign busy    = !fifo_empty || (state != IDLE);

endmodule

// File: tb/tb_apb_master_q.sv
// Directed bench for apb_master_q with a behavioural APB slave driven on the falling edge.
module tb_apb_master_q;

    logic        PCLK;
    logic        PRESETn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_strb;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_timeout;
    logic        busy;
    logic [31:0] PADDR;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PWDATA;
    logic [3:0]  PSTRB;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Slave behaviour knobs, written by the main sequence only while no ACCESS is live.
    int          slave_wait  = 0;
    logic        slave_err   = 1'b0;
    logic        use_fixed   = 1'b0;
    logic [31:0] fixed_rdata = '0;
    int          setup_cyc[$];
    logic [31:0] setup_addr[$];

    apb_master_q #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .DEPTH   (4),
        .TIMEOUT (16)
    ) dut (
        .PCLK        (PCLK),
        .PRESETn     (PRESETn),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .cmd_strb    (cmd_strb),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .rsp_timeout (rsp_timeout),
        .busy        (busy),
        .PADDR       (PADDR),
        .PSEL        (PSEL),
        .PENABLE     (PENABLE),
        .PWRITE      (PWRITE),
        .PWDATA      (PWDATA),
        .PSTRB       (PSTRB),
        .PRDATA      (PRDATA),
        .PREADY      (PREADY),
        .PSLVERR     (PSLVERR)
    );

    initial begin
        PCLK = 1'b0;
        forever #5 PCLK = ~PCLK;
    end

    always @(posedge PCLK) cyc <= cyc + 1;

    function automatic logic [31:0] model_rdata(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    initial begin
        int acc_n;
        acc_n   = 0;
        PREADY  = 1'b0;
        PRDATA  = '0;
        PSLVERR = 1'b0;
        forever begin
            @(negedge PCLK);
            if (PSEL && !PENABLE) begin
                setup_cyc.push_back(cyc);
                setup_addr.push_back(PADDR);
            end
            if (PSEL && PENABLE) begin
                PREADY  = (acc_n >= slave_wait);
                PRDATA  = use_fixed ? fixed_rdata : model_rdata(PADDR);
                PSLVERR = slave_err;
                acc_n++;
            end else begin
                PREADY  = 1'b0;
                PRDATA  = '0;
                PSLVERR = 1'b0;
                acc_n   = 0;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge PCLK);
    endtask

    // Offers one command and returns at the falling edge after the accepting edge.
    task automatic push(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, output int k);
        int budget;
        budget    = 50;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        cmd_strb  = s;
        cmd_valid = 1'b1;
        while (!cmd_ready && budget > 0) begin
            @(negedge PCLK);
            budget--;
        end
        if (budget == 0) check("push_accept_timeout", 1'b0, 1'b1);
        @(posedge PCLK);
        #1;
        k = cyc;
        @(negedge PCLK);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int budget, output logic found, output int at_cyc,
                            output int pen, output logic [31:0] rdata,
                            output logic err, output logic tmo);
        found  = 1'b0;
        at_cyc = 0;
        pen    = 0;
        rdata  = '0;
        err    = 1'b0;
        tmo    = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge PCLK);
            if (PENABLE) pen++;
            if (rsp_valid) begin
                found  = 1'b1;
                at_cyc = cyc;
                rdata  = rsp_rdata;
                err    = rsp_err;
                tmo    = rsp_timeout;
                break;
            end
        end
    endtask

    initial begin
        int          k;
        int          k2;
        int          r0;
        int          at;
        int          pen;
        logic        found;
        logic [31:0] rd;
        logic        er;
        logic        tm;
        logic        psel_seen;
        logic        valid_all;

        PRESETn   = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        cmd_strb  = '0;
        rsp_ready = 1'b1;
        tick(3);

        // Reset state
        check("rst_psel", PSEL, 0);
        check("rst_penable", PENABLE, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_paddr", PADDR, 0);
        check("rst_pstrb", PSTRB, 0);
        PRESETn = 1'b1;
        tick(2);

        // Single zero-wait write
        push(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, k);
        check("w_psel_k", PSEL, 0);
        tick(1);
        check("w_psel_k1", PSEL, 1);
        check("w_penable_k1", PENABLE, 0);
        check("w_paddr", PADDR, 32'h0000_0010);
        check("w_pwrite", PWRITE, 1);
        check("w_pstrb", PSTRB, 4'hF);
        check("w_pwdata", PWDATA, 32'hDEAD_BEEF);
        tick(1);
        check("w_penable_k2", PENABLE, 1);
        tick(1);
        check("w_rsp_valid_k3", rsp_valid, 1);
        check("w_rsp_err", rsp_err, 0);
        check("w_rsp_rdata", rsp_rdata, 0);
        check("w_rsp_timeout", rsp_timeout, 0);
        check("w_psel_off", PSEL, 0);
        tick(2);

        // Read with three wait states
        slave_wait  = 3;
        use_fixed   = 1'b1;
        fixed_rdata = 32'h1234_5678;
        push(1'b0, 32'h0000_0020, 32'h0, 4'hF, k);
        tick(1);
        check("r_pstrb_zero", PSTRB, 0);
        check("r_pwrite", PWRITE, 0);
        wait_rsp(20, found, at, pen, rd, er, tm);
        check("r_found", found, 1);
        check("r_penable_cycles", pen, 4);
        check("r_rsp_cycle", at, k + 6);
        check("r_rdata", rd, 32'h1234_5678);
        check("r_err", er, 0);
        slave_wait = 0;
        use_fixed  = 1'b0;
        tick(2);

        // Queue fill while the response slot is occupied, then drain in order
        rsp_ready = 1'b0;
        push(1'b1, 32'h0000_0080, 32'h1111_2222, 4'h3, k);
        wait_rsp(20, found, at, pen, rd, er, tm);
        check("q_blocker_found", found, 1);
        setup_cyc.delete();
        setup_addr.delete();
        for (int i = 0; i < 4; i++) begin
            push(1'b0, 32'h0000_0100 + 32'(i * 4), 32'h0, 4'h0, k);
        end
        check("q_full_ready", cmd_ready, 0);
        cmd_write = 1'b0;
        cmd_addr  = 32'h0000_0110;
        cmd_valid = 1'b1;
        tick(2);
        check("q_still_full", cmd_ready, 0);
        check("q_stalled_psel", PSEL, 0);
        check("q_busy", busy, 1);
        r0 = cyc;
        rsp_ready = 1'b1;
        push(1'b0, 32'h0000_0110, 32'h0, 4'h0, k2);
        check("q_fifth_accept_cycle", k2, r0 + 2);
        for (int i = 0; i < 5; i++) begin
            wait_rsp(20, found, at, pen, rd, er, tm);
            check($sformatf("q_found_%0d", i), found, 1);
            check($sformatf("q_rdata_%0d", i), rd, model_rdata(32'h0000_0100 + 32'(i * 4)));
            check($sformatf("q_err_%0d", i), er, 0);
        end
        check("q_setup_count", setup_cyc.size(), 5);
        if (setup_cyc.size() == 5) begin
            for (int i = 0; i < 4; i++) begin
                check($sformatf("q_setup_gap_%0d", i), setup_cyc[i+1] - setup_cyc[i], 3);
            end
            for (int i = 0; i < 5; i++) begin
                check($sformatf("q_setup_addr_%0d", i), setup_addr[i], 32'h0000_0100 + 32'(i * 4));
            end
        end
        tick(2);

        // Timeout on a stuck slave, then the next queued read completes normally
        slave_wait = 1000;
        push(1'b0, 32'h0000_0200, 32'h0, 4'h0, k);
        push(1'b0, 32'h0000_0204, 32'h0, 4'h0, k2);
        wait_rsp(40, found, at, pen, rd, er, tm);
        slave_wait = 0;
        check("t_found", found, 1);
        check("t_abort_cycle", at, k + 18);
        check("t_access_cycles", pen, 16);
        check("t_err", er, 1);
        check("t_timeout", tm, 1);
        check("t_rdata", rd, 0);
        check("t_psel_dropped", PSEL, 0);
        wait_rsp(20, found, at, pen, rd, er, tm);
        check("t_next_found", found, 1);
        check("t_next_rdata", rd, model_rdata(32'h0000_0204));
        check("t_next_err", er, 0);
        check("t_next_timeout", tm, 0);
        check("t_next_access_cycles", pen, 1);
        tick(2);

        // PSLVERR on a read, response held off for five cycles
        rsp_ready = 1'b0;
        slave_err = 1'b1;
        push(1'b0, 32'h0000_0300, 32'h0, 4'h0, k);
        push(1'b0, 32'h0000_0304, 32'h0, 4'h0, k2);
        wait_rsp(20, found, at, pen, rd, er, tm);
        slave_err = 1'b0;
        check("e_found", found, 1);
        check("e_err", er, 1);
        check("e_timeout", tm, 0);
        check("e_rdata", rd, model_rdata(32'h0000_0300));
        psel_seen = 1'b0;
        valid_all = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge PCLK);
            psel_seen = psel_seen | PSEL;
            valid_all = valid_all & rsp_valid;
        end
        check("e_no_psel_while_held", psel_seen, 0);
        check("e_rsp_held", valid_all, 1);
        rsp_ready = 1'b1;
        tick(1);
        check("e_psel_after_take", PSEL, 1);
        wait_rsp(20, found, at, pen, rd, er, tm);
        check("e_next_found", found, 1);
        check("e_next_err", er, 0);
        check("e_next_rdata", rd, model_rdata(32'h0000_0304));
        tick(2);

        // Reset in the middle of ACCESS with two commands queued
        slave_wait = 1000;
        push(1'b1, 32'h0000_0400, 32'hAAAA_5555, 4'hF, k);
        push(1'b1, 32'h0000_0404, 32'hBBBB_6666, 4'hF, k);
        push(1'b1, 32'h0000_0408, 32'hCCCC_7777, 4'hF, k);
        check("x_in_access", PENABLE, 1);
        PRESETn = 1'b0;
        #1;
        check("x_psel", PSEL, 0);
        check("x_penable", PENABLE, 0);
        check("x_rsp_valid", rsp_valid, 0);
        check("x_busy", busy, 0);
        check("x_cmd_ready", cmd_ready, 1);
        @(negedge PCLK);
        PRESETn    = 1'b1;
        slave_wait = 0;
        psel_seen  = 1'b0;
        valid_all  = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge PCLK);
            psel_seen = psel_seen | PSEL;
            valid_all = valid_all | rsp_valid;
        end
        check("x_no_transfer_after", psel_seen, 0);
        check("x_no_rsp_after", valid_all, 0);
        check("x_idle_busy", busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
